pc_ctrl: RTL
============

Name: pc_ctrl

Overview:
- Parametrised program-counter controller for the multicycle RV32I core; replaces the single enabled PC register.
- Holds PC, OldPC (the fetched instruction's PC) and EPC; selects among sequential/branch target, trap vector and mret return.
- Detects misaligned targets, runs a boot-hold counter after reset, and supports debug halt/resume.

Parameters:
- XLEN, 32, PC/data width.
- RESET_VECTOR, 32'h0000_0020, PC value after reset.
- TRAP_VECTOR, 32'h0000_0004, PC loaded on any trap.
- IALIGN, 4, required instruction alignment in bytes (2 or 4 only).
- BOOT_HOLD, 2, cycles after reset release during which PC updates are ignored (0 allowed).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pc_next  in  XLEN  candidate PC from ALU/result mux
- pc_write  in  1  request PC <= pc_next
- old_pc_write  in  1  capture current PC into OldPC (fetch cycle)
- trap_req  in  1  take trap this cycle
- trap_cause  in  4  cause code for trap_req
- mret_req  in  1  return from trap: PC <= EPC
- halt_req  in  1  request debug halt
- resume_req  in  1  leave halt
- pc_out  out  XLEN  current PC
- old_pc_out  out  XLEN  PC of instruction in flight
- epc_out  out  XLEN  saved exception PC
- cause_out  out  4  last trap cause
- misalign_fault  out  1  one-cycle pulse on misaligned target
- running  out  1  high only in RUN

Behaviour:
- Reset (rst=1 at a clk edge), all outputs: pc_out=RESET_VECTOR, old_pc_out=RESET_VECTOR, epc_out=0, cause_out=0, misalign_fault=0, running=0. State becomes BOOT, or RUN if BOOT_HOLD=0.
- rst mid-operation overrides every request in the same cycle.
- FSM states: BOOT, RUN, HALTED.
  - BOOT: counter counts BOOT_HOLD cycles after rst deasserts. All requests ignored. BOOT->RUN when count reaches BOOT_HOLD-1; running rises on the following cycle.
  - RUN->HALTED on halt_req. HALTED->RUN on resume_req.
  - halt_req and resume_req together in HALTED: resume wins. In RUN: halt wins.
  - HALTED: pc/old_pc/epc/cause frozen; all update requests ignored.
- Update priority in RUN, one winner per cycle: trap_req > misaligned pc_write > mret_req > pc_write.
  - trap_req: pc <= TRAP_VECTOR, epc <= old_pc, cause <= trap_cause.
  - Misaligned pc_write (pc_next mod IALIGN != 0, low log2(IALIGN) bits nonzero): PC not updated; pc <= TRAP_VECTOR, epc <= old_pc, cause <= 0; misalign_fault=1 in the next cycle only.
  - mret_req: pc <= epc. No alignment check, since EPC is always aligned.
  - pc_write (aligned): pc <= pc_next.
- old_pc_write is independent of the winner. old_pc <= pc as it is before this edge's update, so it is legal together with pc_write in the fetch cycle.
- halt_req in RUN alongside an update: the update is performed, then HALTED.
- All updates take effect at the next clk edge (1-cycle latency). Outputs are registered and there are no combinational input->output paths.
- Arithmetic: no internal adders; PC wrap-around is the caller's concern. pc_next is taken as-is.

Decomposition:
- Shared package pc_pkg: state enum (BOOT, RUN, HALTED), CAUSE_INSN_MISALIGNED=4'd0, IALIGN legality check constant.
- One natural sub-module: en_reg, an enabled register parametrised by width and reset value, instantiated for pc, old_pc, epc and cause.

Test Plan:
- Reset then BOOT_HOLD=2: pc_write=1, pc_next=0x40 in both boot cycles -> pc_out stays 0x20; running=1 from the third post-reset cycle.
- RUN: old_pc_write=1 and pc_write=1, pc_next=0x24 -> pc_out=0x24, old_pc_out=0x20.
- Misaligned: pc_next=0x26, IALIGN=4 -> pc_out=0x04, epc_out=old PC, cause_out=0, misalign_fault high exactly one cycle. With IALIGN=2 -> pc_out=0x26, no fault.
- trap_req (cause 11) together with pc_write and mret_req -> pc_out=0x04, cause_out=11; next mret_req -> pc_out=epc.
- halt_req with pc_write=0x30 -> pc_out=0x30, then frozen for 5 cycles of pc_write/trap_req. resume_req -> updates accepted again next cycle.
- rst asserted while HALTED with trap_req high -> all outputs equal their reset values, state BOOT.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter controller.
//   pc_state_e            : controller state (boot hold, running, debug halt)
//   CAUSE_INSN_MISALIGNED : cause code recorded for a misaligned jump/branch target
//   ialign_legal()        : elaboration-time check of the instruction alignment parameter
package pc_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalted
  } pc_state_e;

  localparam logic [3:0] CAUSE_INSN_MISALIGNED = 4'd0;

  // Only 16-bit (compressed) and 32-bit instruction alignment are meaningful.
  function automatic bit ialign_legal(int unsigned ialign);
    return (ialign == 2) || (ialign == 4);
  endfunction

endpackage

// File: rtl/pc_ctrl_en_reg.sv
// Enabled register with synchronous active-high reset to a parameterised value.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   en       : load enable
//   d        : data in
//   q        : registered data out
module en_reg #(
  parameter int unsigned        WIDTH       = 32,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller for the multicycle RV32I core.
// Holds PC, OldPC (PC of the fetched instruction) and EPC, and chooses the next PC
// among the sequential/branch target, the trap vector and the mret return address.
// Misaligned targets trap instead of loading; a boot-hold counter masks requests
// after reset; debug halt freezes all architectural state.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   pc_next        : candidate PC from the ALU/result mux
//   pc_write       : load pc_next into PC
//   old_pc_write   : capture current PC into OldPC (fetch cycle)
//   trap_req       : take a trap with cause trap_cause
//   mret_req       : return from trap (PC <= EPC)
//   halt_req       : enter debug halt
//   resume_req     : leave debug halt
//   pc_out         : current PC
//   old_pc_out     : PC of the instruction in flight
//   epc_out        : saved exception PC
//   cause_out      : last trap cause
//   misalign_fault : one-cycle pulse after a misaligned target was rejected
//   running        : high only while in the run state
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0020,
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h0000_0004,
  parameter int unsigned       IALIGN       = 4,
  parameter int unsigned       BOOT_HOLD    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_next,
  input  logic            pc_write,
  input  logic            old_pc_write,
  input  logic            trap_req,
  input  logic [3:0]      trap_cause,
  input  logic            mret_req,
  input  logic            halt_req,
  input  logic            resume_req,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] old_pc_out,
  output logic [XLEN-1:0] epc_out,
  output logic [3:0]      cause_out,
  output logic            misalign_fault,
  output logic            running
);

  if (!ialign_legal(IALIGN)) begin : g_bad_ialign
    $error("pc_ctrl: IALIGN must be 2 or 4");
  end

  localparam int unsigned     CNT_W       = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BOOT_HOLD - 1);
  localparam logic [XLEN-1:0] ALIGN_MASK  = XLEN'(IALIGN - 1);
  // With no hold configured, reset lands directly in the run state.
  localparam pc_state_e       RESET_STATE = (BOOT_HOLD == 0) ? StRun : StBoot;

  pc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  logic             running_q;

  logic             pc_en, old_pc_en, epc_en, cause_en;
  logic [XLEN-1:0]  pc_d;
  logic [3:0]       cause_d;
  logic             target_misaligned;

  assign target_misaligned = |(pc_next & ALIGN_MASK);

  // Next-state and update selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fault_d   = 1'b0;
    pc_en     = 1'b0;
    pc_d      = pc_next;
    old_pc_en = 1'b0;
    epc_en    = 1'b0;
    cause_en  = 1'b0;
    cause_d   = trap_cause;

    unique case (state_q)
      StBoot: begin
        if (cnt_q == CNT_LAST) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StRun: begin
        // OldPC samples the pre-update PC, so it can share the cycle with pc_write.
        old_pc_en = old_pc_write;
        if (trap_req) begin
          pc_en    = 1'b1;
          pc_d     = TRAP_VECTOR;
          epc_en   = 1'b1;
          cause_en = 1'b1;
          cause_d  = trap_cause;
        end else if (pc_write && target_misaligned) begin
          pc_en    = 1'b1;
          pc_d     = TRAP_VECTOR;
          epc_en   = 1'b1;
          cause_en = 1'b1;
          cause_d  = CAUSE_INSN_MISALIGNED;
          fault_d  = 1'b1;
        end else if (mret_req) begin
          pc_en = 1'b1;
          pc_d  = epc_out;
        end else if (pc_write) begin
          pc_en = 1'b1;
          pc_d  = pc_next;
        end
        // The update above still lands on the halting edge.
        if (halt_req) begin
          state_d = StHalted;
        end
      end

      StHalted: begin
        if (resume_req) begin
          state_d = StRun;
        end
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      running_q <= (state_d == StRun);
    end
  end

  en_reg #(
    .WIDTH       (XLEN),
    .RESET_VALUE (RESET_VECTOR)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_d),
    .q   (pc_out)
  );

  en_reg #(
    .WIDTH       (XLEN),
    .RESET_VALUE (RESET_VECTOR)
  ) u_old_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (old_pc_en),
    .d   (pc_out),
    .q   (old_pc_out)
  );

  en_reg #(
    .WIDTH       (XLEN),
    .RESET_VALUE ('0)
  ) u_epc_reg (
    .clk (clk),
    .rst (rst),
    .en  (epc_en),
    .d   (old_pc_out),
    .q   (epc_out)
  );

  en_reg #(
    .WIDTH       (4),
    .RESET_VALUE (4'd0)
  ) u_cause_reg (
    .clk (clk),
    .rst (rst),
    .en  (cause_en),
    .d   (cause_d),
    .q   (cause_out)
  );

  assign misalign_fault = fault_q;
  assign running        = running_q;

endmodule
